// File: rtl/kws_nn_pkg.sv
// kws_nn_pkg: shared bias-word geometry, FSM states and request-count clamp for the KWS NN datapath
package kws_nn_pkg;
  localparam int LANES = 36;
  localparam int DW = 8;
  localparam int BIAS_WORD_W = LANES * DW;
  localparam int BIAS_DEPTH = 13;
  localparam int AW = 4;
  localparam int CW = 6;
  localparam int ROM_LATENCY = 1;
  typedef enum logic [1:0] {IDLE, ADDR, CAPT, STREAM} state_e;
  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
    return (c == '0 || c > CW'(LANES)) ? CW'(LANES) : c;
  endfunction
endpackage

// File: rtl/bias_word_serializer.sv
// bias_word_serializer: shifts a packed bias word out MSB lane first, one lane per accepted beat
module bias_word_serializer
  import kws_nn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   active,
  input  logic [BIAS_WORD_W-1:0] word,
  input  logic [CW-1:0]          cnt,
  input  logic                   bias_ready,
  output logic                   bias_valid,
  output logic [DW-1:0]          bias_data,
  output logic [CW-1:0]          bias_lane,
  output logic                   bias_last,
  output logic                   done
);
  logic [BIAS_WORD_W-1:0] sh_q, sh_d;
  logic [CW-1:0] lane_q, lane_d;
  logic beat;
  always_comb begin
    beat = active && bias_ready;
    bias_valid = active;
    bias_data = sh_q[BIAS_WORD_W-1 -: DW];
    bias_lane = lane_q;
    bias_last = active && lane_q == cnt - 1'b1;
    done = beat && bias_last;
    sh_d = load ? word : beat ? sh_q << DW : sh_q;
    lane_d = load ? '0 : beat ? lane_q + 1'b1 : lane_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_q <= '0;
      lane_q <= '0;
    end else begin
      sh_q <= sh_d;
      lane_q <= lane_d;
    end
  end
endmodule

// File: rtl/bias_fetch_serializer.sv
// bias_fetch_serializer: fetches a bias word from the registered ROM and streams its lanes on valid/ready
module bias_fetch_serializer
  import kws_nn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AW-1:0]          req_addr,
  input  logic [CW-1:0]          req_count,
  output logic [AW-1:0]          rom_addr,
  output logic                   rom_in_valid,
  input  logic [BIAS_WORD_W-1:0] rom_w,
  output logic                   bias_valid,
  input  logic                   bias_ready,
  output logic [DW-1:0]          bias_data,
  output logic [CW-1:0]          bias_lane,
  output logic                   bias_last,
  output logic                   err_addr
);
  state_e state_q, state_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic rom_in_valid_q, rom_in_valid_d, err_addr_q, err_addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] wait_q, wait_d;
  logic accept, load, done;
  always_comb begin
    accept = req_valid && state_q == IDLE;
    state_d = state_q;
    rom_addr_d = rom_addr_q;
    rom_in_valid_d = 1'b0;
    err_addr_d = 1'b0;
    cnt_d = cnt_q;
    wait_d = wait_q;
    load = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        cnt_d = clamp_count(req_count);
        if (req_addr >= AW'(BIAS_DEPTH)) err_addr_d = 1'b1;
        else begin
          rom_addr_d = req_addr;
          rom_in_valid_d = 1'b1;
          wait_d = '0;
          state_d = ADDR;
        end
      end
      // one cycle for the ROM to sample the address, then ROM_LATENCY for the word
      ADDR: begin
        wait_d = wait_q + 1'b1;
        if (wait_q == 2'(ROM_LATENCY)) state_d = CAPT;
      end
      CAPT: begin
        load = 1'b1;
        state_d = STREAM;
      end
      STREAM: if (done) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rom_addr_q <= '0;
      rom_in_valid_q <= 1'b0;
      err_addr_q <= 1'b0;
      cnt_q <= '0;
      wait_q <= '0;
    end else begin
      state_q <= state_d;
      rom_addr_q <= rom_addr_d;
      rom_in_valid_q <= rom_in_valid_d;
      err_addr_q <= err_addr_d;
      cnt_q <= cnt_d;
      wait_q <= wait_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rom_addr = rom_addr_q;
  assign rom_in_valid = rom_in_valid_q;
  assign err_addr = err_addr_q;
  bias_word_serializer u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .active     (state_q == STREAM),
    .word       (rom_w),
    .cnt        (cnt_q),
    .bias_ready (bias_ready),
    .bias_valid (bias_valid),
    .bias_data  (bias_data),
    .bias_lane  (bias_lane),
    .bias_last  (bias_last),
    .done       (done)
  );
endmodule

// File: tb/tb_bias_fetch_serializer.sv
// tb_bias_fetch_serializer: random ROM contents and requests checked against a lane-list reference model
module tb_bias_fetch_serializer;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready;
  logic [3:0] req_addr = 0, rom_addr;
  logic [5:0] req_count = 0, bias_lane;
  logic rom_in_valid, bias_valid, bias_ready = 1, bias_last, err_addr;
  logic [287:0] rom_w = '0;
  logic [7:0] bias_data;
  logic [287:0] mem [16];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) rom_w <= mem[rom_addr];

  bias_fetch_serializer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_count(req_count), .rom_addr(rom_addr),
    .rom_in_valid(rom_in_valid), .rom_w(rom_w), .bias_valid(bias_valid),
    .bias_ready(bias_ready), .bias_data(bias_data), .bias_lane(bias_lane),
    .bias_last(bias_last), .err_addr(err_addr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // expected lanes of a request: MSB byte first, count 0 or >36 means all 36
  task automatic stream_check(input int addr, input int cnt, input int mode, input int abort);
    logic [287:0] w;
    logic [7:0] exp_q[$];
    int n, i, it;
    bit seen;
    w = mem[addr];
    n = (cnt == 0 || cnt > 36) ? 36 : cnt;
    for (int k = 0; k < n; k++) exp_q.push_back(w[287-8*k -: 8]);
    i = 0;
    it = 0;
    seen = 0;
    while (i < n) begin
      @(negedge clk);
      if (it > 500) begin
        chk("timeout", 64'(i), 64'(n));
        return;
      end
      if (it == 1) chk("rom_in_valid_drop", 64'(rom_in_valid), 0);
      chk("req_ready_busy", 64'(req_ready), 0);
      if (bias_valid) begin
        if (!seen) chk("first_beat_latency", 64'(it), 3);
        seen = 1;
        chk("bias_data", 64'(bias_data), 64'(exp_q[i]));
        chk("bias_lane", 64'(bias_lane), 64'(i));
        chk("bias_last", 64'(bias_last), 64'(i == n - 1));
        if (abort > 0 && i == abort) begin
          rst_n = 0;
          return;
        end
      end
      bias_ready = mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bias_valid && bias_ready) i++;
      it++;
    end
    @(negedge clk);
    chk("valid_after_last", 64'(bias_valid), 0);
    chk("ready_after_last", 64'(req_ready), 1);
  endtask

  task automatic do_req(input int addr, input int cnt, input int mode, input int abort);
    @(negedge clk);
    chk("req_ready_idle", 64'(req_ready), 1);
    req_valid = 1;
    req_addr = 4'(addr);
    req_count = 6'(cnt);
    @(posedge clk);
    #1;
    req_valid = 0;
    if (addr >= 13) begin
      chk("err_pulse", 64'(err_addr), 1);
      chk("err_no_rom", 64'(rom_in_valid), 0);
      chk("err_ready", 64'(req_ready), 1);
      @(posedge clk);
      #1;
      chk("err_drop", 64'(err_addr), 0);
      chk("err_no_rom2", 64'(rom_in_valid), 0);
      chk("err_no_valid", 64'(bias_valid), 0);
    end else begin
      chk("rom_in_valid", 64'(rom_in_valid), 1);
      chk("rom_addr", 64'(rom_addr), 64'(addr));
      chk("err_quiet", 64'(err_addr), 0);
      stream_check(addr, cnt, mode, abort);
    end
  endtask

  initial begin
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 36; b++) mem[a][8*b +: 8] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 1);
    chk("rst_bias_valid", 64'(bias_valid), 0);
    chk("rst_rom_in_valid", 64'(rom_in_valid), 0);
    chk("rst_err", 64'(err_addr), 0);
    chk("rst_data", 64'(bias_data), 0);
    chk("rst_lane", 64'(bias_lane), 0);
    chk("rst_last", 64'(bias_last), 0);
    chk("rst_rom_addr", 64'(rom_addr), 0);
    rst_n = 1;
    do_req(0, 0, 0, 0);
    do_req(12, 12, 0, 0);
    do_req(4, 0, 1, 0);
    do_req(13, 5, 0, 0);
    do_req(15, 0, 0, 0);
    do_req(5, 50, 1, 0);
    do_req(6, 1, 1, 0);
    do_req(7, 0, 0, 10);
    @(posedge clk);
    #1;
    chk("midrst_valid", 64'(bias_valid), 0);
    chk("midrst_ready", 64'(req_ready), 1);
    rst_n = 1;
    do_req(1, 0, 0, 0);
    @(negedge clk);
    req_valid = 1;
    req_addr = 2;
    req_count = 7;
    @(posedge clk);
    #1;
    req_addr = 3;
    req_count = 9;
    stream_check(2, 7, 1, 0);
    @(posedge clk);
    #1;
    req_valid = 0;
    chk("b2b_rom_in_valid", 64'(rom_in_valid), 1);
    chk("b2b_rom_addr", 64'(rom_addr), 3);
    stream_check(3, 9, 0, 0);
    for (int r = 0; r < 20; r++)
      do_req($urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 1), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
